// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler entry
// address and the bit-field positions inside SR and Cause.
package cp0_unit_pkg;

  localparam logic [4:0]  CP0_SR    = 5'd12;
  localparam logic [4:0]  CP0_CAUSE = 5'd13;
  localparam logic [4:0]  CP0_EPC   = 5'd14;
  localparam logic [4:0]  CP0_PRID  = 5'd15;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  localparam logic [4:0]  EXC_INT     = 5'd0;
  localparam logic [4:0]  EXC_ADEL    = 5'd4;
  localparam logic [4:0]  EXC_ADES    = 5'd5;
  localparam logic [4:0]  EXC_SYSCALL = 5'd8;
  localparam logic [4:0]  EXC_RI      = 5'd10;
  localparam logic [4:0]  EXC_OV      = 5'd12;

  // Field positions; IM in SR and IP in Cause share the same bit range.
  localparam int IM_LO   = 10;
  localparam int IM_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int EXC_LO  = 2;
  localparam int EXC_HI  = 6;

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 signal bundle; the pipeline is the master, CP0 the slave.
interface cp0_unit_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic        req;

  modport master (
    output we, addr, wdata, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    input  rdata, epc_out, req
  );

  modport slave (
    input  we, addr, wdata, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    output rdata, epc_out, req
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId, exception and interrupt
// arbitration, and the combinational flush/redirect request.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2023_0707
) (
  input  logic       clk,
  input  logic       reset,
  cp0_unit_if.slave  bus
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  assign w_int_req = r_ie & ~r_exl & (|(bus.hw_int & r_im));
  assign w_exc_req = (bus.exc_code_in != EXC_INT) & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;

  always_comb begin
    w_sr                  = '0;
    w_sr[IM_HI:IM_LO]     = r_im;
    w_sr[EXL_BIT]         = r_exl;
    w_sr[IE_BIT]          = r_ie;
    w_cause               = '0;
    w_cause[BD_BIT]       = r_bd;
    w_cause[IP_HI:IP_LO]  = r_ip;
    w_cause[EXC_HI:EXC_LO] = r_exc_code;
  end

  // NOTE: every state register uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= bus.hw_int;
      if (w_req) begin
        // Interrupts outrank a pending exception and record code 0.
        r_exl      <= 1'b1;
        r_bd       <= bus.bd_in;
        r_exc_code <= w_int_req ? EXC_INT : bus.exc_code_in;
        r_epc      <= bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
      end else begin
        if (bus.we && bus.addr == CP0_SR) begin
          r_im  <= bus.wdata[IM_HI:IM_LO];
          r_exl <= bus.wdata[EXL_BIT];
          r_ie  <= bus.wdata[IE_BIT];
        end
        if (bus.we && bus.addr == CP0_EPC)
          r_epc <= bus.wdata;
        // Placed after the SR write so eret's clear overrides a written EXL.
        if (bus.exl_clr)
          r_exl <= 1'b0;
      end
    end
  end

  // NOTE: default assignment before the case keeps this purely combinational.
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      CP0_SR:    bus.rdata = w_sr;
      CP0_CAUSE: bus.rdata = w_cause;
      CP0_EPC:   bus.rdata = r_epc;
      CP0_PRID:  bus.rdata = PRID_VALUE;
      default:   bus.rdata = '0;
    endcase
  end

  assign bus.epc_out = r_epc;
  assign bus.req     = w_req;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit: register access, exception and
// interrupt entry, EXL masking, dropped writes and reset mid-handler.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2023_0707;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cp0_unit_if bus ();

  cp0_unit #(.PRID_VALUE(PRID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step();
    bus.we    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.vpc = '0;
    bus.bd_in = 1'b0; bus.exc_code_in = '0; bus.hw_int = '0; bus.exl_clr = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    rd(5'd12, "rst_sr", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);
    rd(5'd15, "rst_prid", PRID);
    check("rst_req", {31'b0, bus.req}, 32'h0);
    check("rst_epc_out", bus.epc_out, 32'h0);

    // Interrupt entry
    mtc0(5'd12, 32'h0000_FC01);
    rd(5'd12, "sr_write", 32'h0000_FC01);
    check("no_int_req", {31'b0, bus.req}, 32'h0);
    bus.hw_int = 6'b000100;
    bus.vpc    = 32'h0000_2000;
    #1;
    check("int_req", {31'b0, bus.req}, 32'h1);
    step();
    rd(5'd13, "int_cause", 32'h0000_1000);
    rd(5'd12, "int_sr_exl", 32'h0000_FC03);
    rd(5'd14, "int_epc", 32'h0000_2000);
    check("int_epc_out", bus.epc_out, 32'h0000_2000);

    // Exception in a delay slot
    bus.hw_int  = '0;
    bus.exl_clr = 1'b1;
    step();
    bus.exl_clr = 1'b0;
    rd(5'd12, "eret_sr", 32'h0000_FC01);
    bus.exc_code_in = 5'd12;
    bus.bd_in       = 1'b1;
    bus.vpc         = 32'h0000_3010;
    #1;
    check("exc_req", {31'b0, bus.req}, 32'h1);
    step();
    bus.exc_code_in = '0;
    bus.bd_in       = 1'b0;
    rd(5'd14, "exc_epc_bd", 32'h0000_300C);
    rd(5'd13, "exc_cause", 32'h8000_0030);
    rd(5'd12, "exc_sr", 32'h0000_FC03);

    // EXL masks both exceptions and interrupts
    bus.exc_code_in = 5'd10;
    bus.hw_int      = 6'b000100;
    bus.vpc         = 32'h0000_3100;
    #1;
    check("exl_mask_req", {31'b0, bus.req}, 32'h0);
    step();
    rd(5'd14, "exl_epc_hold", 32'h0000_300C);
    rd(5'd13, "exl_cause_ip", 32'h8000_1030);
    bus.exc_code_in = '0;
    bus.exl_clr     = 1'b1;
    #1;
    check("exl_clr_req", {31'b0, bus.req}, 32'h0);
    step();
    bus.exl_clr = 1'b0;
    rd(5'd12, "clr_sr", 32'h0000_FC01);
    check("reassert_req", {31'b0, bus.req}, 32'h1);
    // Interrupt and exception together: interrupt wins
    bus.exc_code_in = 5'd10;
    bus.vpc         = 32'h0000_3200;
    step();
    bus.exc_code_in = '0;
    bus.hw_int      = '0;
    rd(5'd13, "prio_cause", 32'h0000_1000);
    rd(5'd14, "prio_epc", 32'h0000_3200);

    // mtc0 in the same cycle as an exception is dropped
    bus.exl_clr = 1'b1;
    step();
    bus.exl_clr     = 1'b0;
    bus.we          = 1'b1;
    bus.addr        = 5'd14;
    bus.wdata       = 32'h0000_5000;
    bus.exc_code_in = 5'd4;
    bus.vpc         = 32'h0000_3000;
    #1;
    check("drop_req", {31'b0, bus.req}, 32'h1);
    step();
    bus.we          = 1'b0;
    bus.exc_code_in = '0;
    rd(5'd14, "drop_epc", 32'h0000_3000);
    rd(5'd13, "drop_cause", 32'h0000_0010);

    // Read-only and masked writes
    bus.exl_clr = 1'b1;
    step();
    bus.exl_clr = 1'b0;
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_ro", 32'h0000_0010);
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, "sr_mask", 32'h0000_FC03);
    mtc0(5'd15, 32'h0);
    rd(5'd15, "prid_ro", PRID);
    bus.exl_clr = 1'b1;
    mtc0(5'd12, 32'hFFFF_FFFF);
    bus.exl_clr = 1'b0;
    rd(5'd12, "clr_beats_mtc0", 32'h0000_FC01);
    mtc0(5'd14, 32'h1234_5678);
    rd(5'd14, "epc_write", 32'h1234_5678);
    check("epc_out_write", bus.epc_out, 32'h1234_5678);

    // EPC wrap-around for a delay slot at address 0
    bus.vpc         = 32'h0;
    bus.bd_in       = 1'b1;
    bus.exc_code_in = 5'd5;
    step();
    bus.bd_in       = 1'b0;
    bus.exc_code_in = '0;
    rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
    rd(5'd13, "wrap_cause", 32'h8000_0014);

    // Reset while inside the handler with an interrupt pending
    bus.hw_int = 6'b000100;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(5'd12, "mid_rst_sr", 32'h0);
    rd(5'd13, "mid_rst_cause", 32'h0);
    rd(5'd14, "mid_rst_epc", 32'h0);
    check("mid_rst_req", {31'b0, bus.req}, 32'h0);
    step();
    rd(5'd13, "post_rst_ip", 32'h0000_1000);
    check("post_rst_req", {31'b0, bus.req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block in the memory (M) stage of the 5-stage MIPS pipeline.
- Consumes the M-stage pipeline register outputs: PC, branch-delay flag and exception code. Also consumes the 6-bit external hardware interrupt vector.
- Holds SR, Cause, EPC and PRId. Decides each cycle whether to take an exception or interrupt, and drives the global `req` that flushes all pipeline registers and redirects fetch to 0x0000_4180.
- Executes mtc0/mfc0 accesses and the EXL clear for eret.

Parameters:
- PRID_VALUE, 32'h2023_0707, constant value read from PRId (register 15).
- HANDLER_PC, 32'h0000_4180, exception entry address; exported for F-stage redirect and pipeline flush.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  mtc0 write enable; M-stage instruction is mtc0.
- addr  input  5  CP0 register number (rd field) for mfc0/mtc0.
- wdata  input  32  mtc0 write data (forwarded rt value).
- vpc  input  32  victim PC of the M-stage instruction; word-aligned.
- bd_in  input  1  M-stage instruction is in a branch delay slot.
- exc_code_in  input  5  accumulated exception code from the F/D/E/M stages; 0 means none.
- hw_int  input  6  external interrupt lines, level-sensitive.
- exl_clr  input  1  eret is in the M stage.
- rdata  output  32  mfc0 read data; combinational.
- epc_out  output  32  current EPC, used as the eret target.
- req  output  1  take exception/interrupt this cycle; combinational.

Behaviour:
- SR layout:
  - IM = bits [15:10].
  - EXL = bit [1].
  - IE = bit [0].
  - All other bits read 0 and ignore writes.
- Cause layout:
  - BD = bit [31].
  - IP = bits [15:10].
  - ExcCode = bits [6:2].
  - All other bits read 0.
  - Cause is read-only to mtc0.
- EPC: 32 bits, fully writable by mtc0.
- PRId: constant, read-only.
- Reset values: SR = 0, Cause = 0, EPC = 0. Consequently rdata for any address other than 15 reads 0 after reset, epc_out = 0 and req = 0.
- Interrupt request: `int_req = SR.IE & ~SR.EXL & |(hw_int & SR.IM)`.
- Exception request: `exc_req = (exc_code_in != 0) & ~SR.EXL`.
- Request output: `req = int_req | exc_req`. It is combinational, with the same-cycle effect that the pipeline registers flush on the next edge.
- Priority: an interrupt beats an exception.
  - Interrupt: ExcCode written = 0.
  - Exception only: ExcCode written = exc_code_in.
- On a clock edge with req = 1:
  - SR.EXL <= 1.
  - Cause.BD <= bd_in.
  - Cause.ExcCode as defined by the priority rule.
  - EPC <= bd_in ? vpc - 4 : vpc. Use 32-bit wrap-around subtraction.
- Cause.IP <= hw_int every cycle regardless of req, we or EXL.
- mtc0 write occurs only when we = 1 and req = 0. A write in the same cycle as req is dropped. Targets:
  - addr 12 updates IM/EXL/IE.
  - addr 14 updates EPC.
  - All other addresses are ignored.
- exl_clr = 1 and req = 0 clears SR.EXL on the edge. exl_clr and req cannot both be 1 through the EXL term; if they are, req wins.
- If mtc0 to SR and exl_clr occur together, exl_clr wins for the EXL bit.
- rdata is combinational from the current register values by addr:
  - 12 → SR.
  - 13 → Cause.
  - 14 → EPC.
  - 15 → PRID_VALUE.
  - Other addresses → 0.
- No write-to-read bypass. The hazard unit stalls an eret or mfc0 that depends on an in-flight mtc0.
- Reset mid-handler: reset returns all registers to reset values with EXL = 0. A pending hw_int does not raise req while IE = 0.

Decomposition:
- Shared package holds:
  - CP0 register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15.
  - HANDLER_PC.
  - ExcCode constants: Int = 0, AdEL = 4, AdES = 5, Syscall = 8, RI = 10, Ov = 12.
  - Bit-field positions for IM, IP, EXL, IE, BD and ExcCode.
- Single module; no sub-module. Request logic and register file are small enough to share one file.

Test Plan:
- Reset, then read addr 12/13/14/15 → rdata = 0, 0, 0, PRID_VALUE; req = 0.
- mtc0 SR = 32'h0000_FC01, then hw_int = 6'b000100 → req = 1 the same cycle. Next edge gives Cause = 32'h0000_1000, ExcCode = 0, SR.EXL = 1, EPC = vpc.
- EXL = 0, exc_code_in = 12, bd_in = 1, vpc = 32'h0000_3010 → req = 1. Next edge gives EPC = 32'h0000_300C, Cause = 32'h8000_0030, EXL = 1.
- While EXL = 1: exc_code_in = 10 plus active enabled interrupt → req = 0, EPC unchanged. Then exl_clr = 1 → EXL = 0 and req is reasserted by the still-active interrupt.
- Same cycle: we = 1, addr = 14, wdata = 32'h0000_5000, exc_code_in = 4, vpc = 32'h0000_3000 → write dropped, EPC = 32'h0000_3000.
- mtc0 addr 13 with wdata = 32'hFFFF_FFFF → Cause unchanged. Write to addr 12 with 32'hFFFF_FFFF → SR reads 32'h0000_FC03.
